// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 encodings, the FSM state enum, XLEN and the fixed results
// returned for divide-by-zero and signed overflow. Also provides helpers that
// tell whether each operand of a given funct3 is treated as signed.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [XLEN-1:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring divide iteration (combinational).
// Ports:
//   rem_i     partial remainder (always < divisor)
//   quo_i     dividend bits still to shift in (MSB first) / quotient so far
//   divisor_i divisor magnitude
//   rem_o     next partial remainder
//   quo_o     quotient shifted left with the new quotient bit in the LSB
module div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Because rem_i < divisor, the shifted remainder fits in 33 bits and a
  // borrow in bit 32 of the difference means "does not go".
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Optional feature macro: MULDIV_FAST_MUL_EN -- single-cycle 33x33 multiplier
// instead of the 32-cycle shift-add loop.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        instruction valid, sampled only in IDLE or DONE
//   funct3       M-op select
//   op_a, op_b   rs1 / rs2 operands
//   flush        aborts any operation; wins over start
//   busy         combinational stall request
//   done         one-cycle result-valid pulse
//   result       registered result
//   dbg_state    current FSM state
// Handshake: an op is accepted on a rising edge where start=1, flush=0 and the
// FSM is in IDLE or DONE; busy is high from that cycle until the cycle before
// done; result is valid while done=1 and stays stable until the next accept.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output state_e          dbg_state
);

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  // Shared working registers: divide uses rem/quo/div as remainder, quotient
  // and divisor; shift-add multiply uses them as product-high, product-low
  // (multiplier) and multiplicand.
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, sa, sb, last, ovf;
  logic [XLEN-1:0] step_rem, step_quo, q_fin, r_fin;
  logic [63:0]     mul_prod;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign accept = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sa     = op_a[XLEN-1] && a_is_signed(funct3);
  assign sb     = op_b[XLEN-1] && b_is_signed(funct3);
  assign last   = (cnt_q == 5'd31);
  assign ovf    = !f3_q[0] && (a_q == OVF_DIVIDEND) && (b_q == OVF_DIVISOR);
  assign q_fin  = qneg_q ? (32'd0 - step_quo) : step_quo;
  assign r_fin  = rneg_q ? (32'd0 - step_rem) : step_rem;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fast_a, fast_b;
  assign fast_a   = $signed({a_q[XLEN-1] && a_is_signed(f3_q), a_q});
  assign fast_b   = $signed({b_q[XLEN-1] && b_is_signed(f3_q), b_q});
  assign mul_prod = 64'(fast_a) * 64'(fast_b);
`else
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [63:0]     mul_mag;
  // Shift-add on magnitudes: add multiplicand into the high half when the
  // multiplier LSB is set, then shift the 65-bit {carry,hi,lo} right by one.
  assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, div_q} : 33'd0);
  assign mul_hi   = mul_sum[XLEN:1];
  assign mul_lo   = {mul_sum[0], quo_q[XLEN-1:1]};
  assign mul_mag  = {mul_hi, mul_lo};
  assign mul_prod = qneg_q ? (64'd0 - mul_mag) : mul_mag;
`endif

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          f3_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
          rem_d   = '0;
          quo_d   = sa ? (32'd0 - op_a) : op_a;
          div_d   = sb ? (32'd0 - op_b) : op_b;
          cnt_d   = '0;
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          state_d = funct3[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        result_d = (f3_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
        state_d  = ST_DONE;
`else
        rem_d = mul_hi;
        quo_d = mul_lo;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          result_d = (f3_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
          state_d  = ST_DONE;
        end
`endif
      end
      ST_DIV: begin
        if (b_q == '0) begin
          result_d = f3_q[1] ? a_q : DIV0_QUOT;
          state_d  = ST_DONE;
        end else if (ovf) begin
          result_d = f3_q[1] ? OVF_REM : OVF_QUOT;
          state_d  = ST_DONE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (last) begin
            result_d = f3_q[1] ? r_fin : q_fin;
            state_d  = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy      = accept || (!flush && ((state_q == ST_MUL) || (state_q == ST_DIV)));
  assign done      = (state_q == ST_DONE) && !flush;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
  endtask

  // Called #1 after the accepting edge with start already dropped.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int cyc  = 1;
    int bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat - 1));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy in done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    issue(f3, a, b);
    #1 chk({tag, " busy in start"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, exp_res, exp_lat);
    @(posedge clk); #1;
    chk({tag, " done cleared"}, 32'(done), 32'd0);
    chk({tag, " result held"}, result, exp_res);
  endtask

  initial begin
    int dcnt;

    // Reset state
    #12;
    chk("rst state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst result", result, 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Divide: signed, remainder, special cases
    run_op("DIV -7/2",    F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("REM -7/2",    F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("DIV 7/-2",    F3_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("REM 7/-2",    F3_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
    run_op("REMU 100/7",  F3_REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    run_op("DIVU max/1",  F3_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT);
    run_op("DIVU 100/0",  F3_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 2);
    run_op("REMU 100/0",  F3_REMU, 32'd100,       32'd0,         32'd100,       2);
    run_op("REM -5/0",    F3_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2);
    run_op("DIV ovf",     F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("REM ovf",     F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

    // Multiply variants
    run_op("MUL -3*5",    F3_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MUL_LAT);
    run_op("MULHSU -1*2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
    run_op("MULH min^2",  F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("MULHU max^2", F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);

    // Flush at cycle 10 of a divide; result keeps 0xFFFFFFFE
    @(negedge clk);
    issue(F3_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1 chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush state", 32'(dbg_state), 32'(ST_IDLE));
    chk("flush busy after", 32'(busy), 32'd0);
    chk("flush result", result, 32'hFFFF_FFFE);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("flush no done", 32'(dcnt), 32'd0);

    // Flush beats a simultaneous start
    @(negedge clk);
    issue(F3_MUL, 32'd2, 32'd3);
    flush = 1'b1;
    #1 chk("flush+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush+start state", 32'(dbg_state), 32'(ST_IDLE));

    // Back-to-back: second start in the DONE cycle of the first
    @(negedge clk);
    issue(F3_DIVU, 32'd10, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b DIVU", 32'd3, DIV_LAT);
    issue(F3_MUL, 32'd6, 32'd7);
    #1 chk("b2b busy in done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b state", 32'(dbg_state), MUL_LAT == 2 ? 32'(ST_MUL) : 32'(ST_MUL));
    wait_done("b2b MUL", 32'd42, MUL_LAT);

    // Reset mid-operation, then start on the first edge after release
    @(negedge clk);
    issue(F3_DIVU, 32'd50, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid rst result", result, 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(F3_DIVU, 32'd10, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("post rst DIVU", 32'd3, DIV_LAT);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 start  input  1  EX-stage RV32M instruction valid; sampled only in IDLE or DONE.
REQ-003 funct3  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-004 op_a  input  32  rs1 operand / dividend; op_b  input  32  rs2 operand / divisor.
REQ-005 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-006 busy  output  1  stall request to the pipeline, ORed with the load-use stall by the pipeline.
REQ-007 done  output  1  single-cycle pulse; result valid.
REQ-008 result  output  32  registered result, held until the next accepted start.

Function
REQ-009 The state machine SHALL have the states IDLE, MUL, DIV and DONE.
REQ-010 In IDLE or DONE, start=1 with flush=0 SHALL latch funct3, op_a and op_b and move to MUL when funct3<4, or to DIV when funct3>=4.
REQ-011 busy SHALL equal (start && state in {IDLE,DONE} && !flush) || state in {MUL,DIV}; it SHALL be combinational so the stall lands in the start cycle.
REQ-012 The DIV state SHALL run a radix-2 restoring divide on magnitudes, one quotient bit per cycle, for exactly 32 cycles, then move to DONE.
REQ-013 Signed DIV/REM: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); the unit SHALL correct signs in the final DIV cycle.
REQ-014 Divide by zero (op_b=0): quotient SHALL be 0xFFFFFFFF and remainder SHALL be op_a; the unit SHALL move straight from DIV to DONE after one cycle.
REQ-015 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient SHALL be 0x80000000 and remainder 0; the unit SHALL take one cycle, as for divide by zero.
REQ-016 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] with the operands treated as s*s, s*u and u*u respectively; a 64-bit product SHALL be formed from 33-bit sign-extended operands.
REQ-017 DONE SHALL last exactly one cycle with done=1 and busy=0, and SHALL then return to IDLE unless a new start is accepted.
REQ-018 Latency from the accepted start edge to done SHALL be: DIV 33 cycles; divide by zero or overflow 2 cycles; MUL per REQ-023/REQ-024.
REQ-019 flush=1 in any state SHALL force IDLE at the next edge, suppress done, leave result unchanged and drive busy=0 in that cycle; flush SHALL take priority over a simultaneous start.
REQ-020 start asserted in MUL or DIV SHALL be ignored, because the pipeline is stalled and holds the instruction.

Reset
REQ-021 While rst_n=0 the unit SHALL be in state IDLE with result=0, done=0, busy=0, and all internal counters and operand registers cleared.
REQ-022 Reset asserted mid-operation SHALL abort immediately with no done pulse; after reset is released the unit SHALL accept a start on the first clock edge.

Configuration
REQ-023 With MULDIV_FAST_MUL_EN defined, MUL-class ops SHALL use a single-cycle 33x33 multiplier, so MUL lasts 1 cycle and done is asserted 2 cycles after the accepted start.
REQ-024 Without MULDIV_FAST_MUL_EN, MUL-class ops SHALL use a 32-cycle shift-add iteration, giving 33-cycle latency, and SHALL share the cycle counter with DIV; the external behaviour is otherwise identical.

Structure
REQ-025 The shared package muldiv_pkg SHALL hold the funct3 encoding constants, the state enum, the XLEN=32 constant, and the divide-by-zero and overflow constants.
REQ-026 The per-cycle restoring subtract/shift step SHALL be a combinational sub-module named div_step: inputs are the partial remainder, quotient and divisor; outputs are the next remainder and quotient.

Verification
REQ-027 DIV with op_a=0xFFFFFFF9 (-7) and op_b=2 -> busy high for 33 cycles, then done with result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFF (-1).
REQ-028 DIVU with op_a=100 and op_b=0 -> done 2 cycles after start with result=0xFFFFFFFF; REMU with the same operands -> result=100.
REQ-029 DIV with op_a=0x80000000 and op_b=0xFFFFFFFF -> result=0x80000000; REM with the same operands -> result=0.
REQ-030 MULH with op_a=0x80000000 and op_b=0x80000000 -> result=0x40000000; MULHU with op_a=0xFFFFFFFF and op_b=0xFFFFFFFF -> result=0xFFFFFFFE; latency checked both with and without MULDIV_FAST_MUL_EN.
REQ-031 flush at cycle 10 of a DIV -> state is IDLE the next cycle, busy=0, no done pulse, and result still holds the prior value.
REQ-032 Back-to-back start in the DONE cycle (DIVU 10/3, then MUL 6*7) -> first done with result=3, second done with result=42, with no idle cycle between the two operations.
